// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: widths, opcodes and FSM states.
package cpu_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int OP_W   = 4;

   localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OP_W-1:0] OP_LDA  = 4'h1;
   localparam logic [OP_W-1:0] OP_STA  = 4'h2;
   localparam logic [OP_W-1:0] OP_ADD  = 4'h3;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h4;
   localparam logic [OP_W-1:0] OP_AND  = 4'h5;
   localparam logic [OP_W-1:0] OP_JMP  = 4'h6;
   localparam logic [OP_W-1:0] OP_JZ   = 4'h7;
   localparam logic [OP_W-1:0] OP_HALT = 4'hF;

   typedef enum logic [3:0] {
      FETCH0, FETCH1, FETCH2, DECODE, MEM0, MEM1, MEM2, EXEC, STORE, HALT
   } state_t;

   function automatic logic is_read_op(input logic [OP_W-1:0] op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
   endfunction
endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU: next AC value and its zero flag for LDA/ADD/SUB/AND.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] ac,
   input  logic [DATA_W-1:0] operand,
   output logic [DATA_W-1:0] result,
   output logic              zero
);
   always_comb begin
      result = ac;
      case (op)
         OP_LDA:  result = operand;
         OP_ADD:  result = ac + operand;
         OP_SUB:  result = ac - operand;
         OP_AND:  result = ac & operand;
         default: result = ac;
      endcase
      zero = (result == '0);
   end
endmodule

// File: rtl/cpu.sv
// Accumulator CPU: fetch/decode/execute FSM driving a synchronous memory through
// registered MAR/data_out/Mem_CS/Mem_EN; read data is taken two edges after its CS pulse.
module cpu
   import cpu_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] MAR,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              Mem_EN,
   output logic              Mem_CS,
   output logic              halted
);
   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   pc, pc_nxt;
   logic [DATA_W-1:0]   ir, ir_nxt;
   logic [DATA_W-1:0]   ac, ac_nxt;
   logic [DATA_W-1:0]   operand, operand_nxt;
   logic                z, z_nxt;
   logic [ADDR_W-1:0]   mar_nxt;
   logic [DATA_W-1:0]   dout_nxt;
   logic                cs_nxt, en_nxt, halted_nxt;

   logic [OP_W-1:0]     op;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_zero;
   logic                unused_ir_bits;

   assign op             = ir[15:12];
   assign addr           = ir[ADDR_W-1:0];
   assign unused_ir_bits = ^ir[11:8];

   cpu_alu u_alu (
      .op      (op),
      .ac      (ac),
      .operand (operand),
      .result  (alu_result),
      .zero    (alu_zero)
   );

   // Strobes default low so every access is a single-cycle CS pulse.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      ir_nxt      = ir;
      ac_nxt      = ac;
      operand_nxt = operand;
      z_nxt       = z;
      mar_nxt     = MAR;
      dout_nxt    = data_out;
      cs_nxt      = 1'b0;
      en_nxt      = 1'b0;
      halted_nxt  = halted;
      case (state)
         FETCH0: begin
            mar_nxt   = pc;
            cs_nxt    = 1'b1;
            state_nxt = FETCH1;
         end
         FETCH1: state_nxt = FETCH2;
         FETCH2: begin
            ir_nxt    = data_in;
            pc_nxt    = pc + 8'd1;
            state_nxt = DECODE;
         end
         DECODE: begin
            state_nxt = FETCH0;
            if (is_read_op(op)) begin
               mar_nxt   = addr;
               cs_nxt    = 1'b1;
               state_nxt = MEM0;
            end else if (op == OP_STA) begin
               mar_nxt   = addr;
               dout_nxt  = ac;
               cs_nxt    = 1'b1;
               en_nxt    = 1'b1;
               state_nxt = STORE;
            end else if (op == OP_JMP) begin
               pc_nxt = addr;
            end else if (op == OP_JZ) begin
               if (z) pc_nxt = addr;
            end else if (op == OP_HALT) begin
               halted_nxt = 1'b1;
               state_nxt  = HALT;
            end
         end
         MEM0: state_nxt = MEM1;
         // Second edge after the operand CS pulse: memory output is valid here.
         MEM1: begin
            operand_nxt = data_in;
            state_nxt   = MEM2;
         end
         MEM2: state_nxt = EXEC;
         EXEC: begin
            ac_nxt    = alu_result;
            z_nxt     = alu_zero;
            state_nxt = FETCH0;
         end
         STORE:   state_nxt = FETCH0;
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= FETCH0;
         pc       <= '0;
         ir       <= '0;
         ac       <= '0;
         operand  <= '0;
         z        <= 1'b1;
         MAR      <= '0;
         data_out <= '0;
         Mem_CS   <= 1'b0;
         Mem_EN   <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         ir       <= ir_nxt;
         ac       <= ac_nxt;
         operand  <= operand_nxt;
         z        <= z_nxt;
         MAR      <= mar_nxt;
         data_out <= dout_nxt;
         Mem_CS   <= cs_nxt;
         Mem_EN   <= en_nxt;
         halted   <= halted_nxt;
      end
   end
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: behavioural memory, ISA-level timing model, table vectors, random programs.
module tb_cpu;
   import cpu_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  MAR;
   logic [15:0] data_in, data_out;
   logic        Mem_EN, Mem_CS, halted;

   cpu dut (
      .clock(clock), .reset(reset), .MAR(MAR), .data_in(data_in),
      .data_out(data_out), .Mem_EN(Mem_EN), .Mem_CS(Mem_CS), .halted(halted)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          cyc;
      logic [7:0]  addr;
      logic        we;
      logic [15:0] dat;
   } acc_t;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      bit          taken;
   } vec_t;

   acc_t        act_q[$];
   acc_t        exp_q[$];
   logic [15:0] mem [256];
   logic [15:0] img [256];
   logic [15:0] mm  [256];
   logic        load = 1'b0;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          limit = 0;
   int          halt_cyc = -1;
   bit          prev_cs = 1'b0;

   always @(posedge clock) begin
      if (load) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
         data_in <= '0;
      end else if (Mem_CS) begin
         if (Mem_EN) mem[MAR] <= data_out;
         else        data_in  <= mem[MAR];
      end
   end

   task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic step();
      acc_t a;
      @(posedge clock);
      #1;
      cyc++;
      chk(!(Mem_CS && prev_cs), "cs_back_to_back", {31'd0, Mem_CS}, 0);
      chk(!(Mem_EN && !Mem_CS), "en_without_cs", {31'd0, Mem_EN}, 0);
      prev_cs = Mem_CS;
      if (Mem_CS && cyc < limit) begin
         a.cyc = cyc; a.addr = MAR; a.we = Mem_EN; a.dat = data_out;
         act_q.push_back(a);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      load  = 1'b1;
      @(posedge clock);
      #1;
      load = 1'b0;
      chk(MAR == 0 && data_out == 0 && !Mem_CS && !Mem_EN && !halted, "reset_state",
          {5'd0, Mem_CS, Mem_EN, halted, MAR, data_out}, 0);
      @(negedge clock);
      reset   = 1'b0;
      cyc     = 0;
      prev_cs = 1'b0;
      act_q.delete();
   endtask

   // Instruction-level model: each instruction starts at cycle t (FETCH0); its
   // fetch strobe is seen at t+1, an operand/store strobe at t+4.
   task automatic model_run(input int n);
      logic [7:0]  pc = 0;
      logic [15:0] ac = 0, ins, v;
      bit          z = 1'b1;
      int          t = 0;
      acc_t        a;
      exp_q.delete();
      halt_cyc = -1;
      for (int i = 0; i < 256; i++) mm[i] = img[i];
      while (t < n) begin
         ins = mm[pc];
         a.cyc = t + 1; a.addr = pc; a.we = 1'b0; a.dat = 0;
         if (a.cyc < n) exp_q.push_back(a);
         pc = pc + 8'd1;
         case (ins[15:12])
            4'h1, 4'h3, 4'h4, 4'h5: begin
               a.cyc = t + 4; a.addr = ins[7:0]; a.we = 1'b0; a.dat = 0;
               if (a.cyc < n) exp_q.push_back(a);
               v = mm[ins[7:0]];
               case (ins[15:12])
                  4'h1:    ac = v;
                  4'h3:    ac = ac + v;
                  4'h4:    ac = ac - v;
                  default: ac = ac & v;
               endcase
               z = (ac == 0);
               t += 8;
            end
            4'h2: begin
               a.cyc = t + 4; a.addr = ins[7:0]; a.we = 1'b1; a.dat = ac;
               if (a.cyc < n) exp_q.push_back(a);
               mm[ins[7:0]] = ac;
               t += 5;
            end
            4'h6: begin pc = ins[7:0]; t += 4; end
            4'h7: begin if (z) pc = ins[7:0]; t += 4; end
            4'hF: begin halt_cyc = t + 4; break; end
            default: t += 4;
         endcase
      end
   endtask

   task automatic run_prog(input int n);
      bit          exp_halt;
      int          m, diffs, pulses;
      logic [7:0]  mar0;
      logic [15:0] dout0;
      limit = n;
      model_run(n);
      do_reset();
      while (cyc < n - 1) step();
      exp_halt = (halt_cyc >= 0) && (halt_cyc <= n - 1);
      chk(halted == exp_halt, "halted", {31'd0, halted}, {31'd0, exp_halt});
      chk(act_q.size() == exp_q.size(), "access_count", act_q.size(), exp_q.size());
      m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         chk(act_q[i].cyc == exp_q[i].cyc && act_q[i].addr == exp_q[i].addr &&
             act_q[i].we == exp_q[i].we && (!exp_q[i].we || act_q[i].dat == exp_q[i].dat),
             $sformatf("access%0d", i),
             {act_q[i].cyc[6:0], act_q[i].we, act_q[i].addr, act_q[i].dat},
             {exp_q[i].cyc[6:0], exp_q[i].we, exp_q[i].addr, exp_q[i].dat});
      end
      if (exp_halt) begin
         diffs = 0;
         for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) diffs++;
         chk(diffs == 0, "final_mem", diffs, 0);
         mar0 = MAR; dout0 = data_out; pulses = 0;
         repeat (50) begin
            step();
            if (Mem_CS) pulses++;
         end
         chk(pulses == 0 && MAR == mar0 && data_out == dout0 && halted, "halt_stable",
             {pulses[6:0], halted, MAR, data_out}, {8'd1, mar0, dout0});
      end
   endtask

   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = 16'h0000;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[9];
      logic [15:0] r;
      logic [3:0]  op;
      int          nxt, writes;

      vecs[0] = '{4'h3, 16'd5,    16'd7,    16'd12,   1'b0};
      vecs[1] = '{4'h4, 16'd9,    16'd9,    16'd0,    1'b1};
      vecs[2] = '{4'h4, 16'd9,    16'd8,    16'd1,    1'b0};
      vecs[3] = '{4'h4, 16'd0,    16'd1,    16'hFFFF, 1'b0};
      vecs[4] = '{4'h3, 16'hFFFF, 16'd1,    16'd0,    1'b1};
      vecs[5] = '{4'h5, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0};
      vecs[6] = '{4'h5, 16'h00FF, 16'hFF00, 16'd0,    1'b1};
      vecs[7] = '{4'h3, 16'h8000, 16'h8000, 16'd0,    1'b1};
      vecs[8] = '{4'h1, 16'd7,    16'd0,    16'd0,    1'b1};

      // Asynchronous reset in the middle of a fetch strobe.
      clear_img();
      limit = 1000;
      do_reset();
      repeat (9) step();
      chk(Mem_CS && !Mem_EN && MAR == 8'd2, "pre_reset_fetch", {Mem_CS, Mem_EN, MAR}, {2'b10, 8'd2});
      #2;
      reset = 1'b1;
      #1;
      chk(!Mem_CS && !Mem_EN && MAR == 0, "async_reset", {Mem_CS, Mem_EN, MAR}, 0);
      do_reset();
      step();
      chk(Mem_CS && !Mem_EN && MAR == 0, "first_fetch_addr0", {Mem_CS, Mem_EN, MAR}, {2'b10, 8'd0});

      // Load/add/store with a single write pulse.
      clear_img();
      img[0] = 16'h100A; img[1] = 16'h300B; img[2] = 16'h200C; img[3] = 16'hF000;
      img[10] = 16'd5;   img[11] = 16'd7;
      run_prog(60);
      writes = 0;
      foreach (act_q[i]) if (act_q[i].we) writes++;
      chk(mem[12] == 16'd12, "las_result", mem[12], 16'd12);
      chk(writes == 1, "las_write_pulses", writes, 1);
      chk(halted, "las_halted", {31'd0, halted}, 1);

      // ALU result, Z flag and JZ direction per vector.
      foreach (vecs[k]) begin
         clear_img();
         img[0] = 16'h1010;
         img[1] = {vecs[k].op, 12'h011};
         img[2] = 16'h7020;
         img[3] = 16'h2012;
         img[4] = 16'hF000;
         img[8'h20] = 16'h2013;
         img[8'h21] = 16'hF000;
         img[8'h10] = vecs[k].a;
         img[8'h11] = vecs[k].b;
         img[8'h12] = 16'hDEAD;
         img[8'h13] = 16'hDEAD;
         run_prog(80);
         nxt = -1;
         for (int i = 0; i + 1 < act_q.size(); i++)
            if (act_q[i].addr == 8'd2 && !act_q[i].we && nxt < 0) nxt = act_q[i + 1].addr;
         chk(nxt == (vecs[k].taken ? 32'h20 : 32'h03), $sformatf("vec%0d_jz_target", k),
             nxt, vecs[k].taken ? 32'h20 : 32'h03);
         chk(mem[vecs[k].taken ? 8'h13 : 8'h12] == vecs[k].res, $sformatf("vec%0d_result", k),
             mem[vecs[k].taken ? 8'h13 : 8'h12], vecs[k].res);
         chk(mem[vecs[k].taken ? 8'h12 : 8'h13] == 16'hDEAD, $sformatf("vec%0d_untouched", k),
             mem[vecs[k].taken ? 8'h12 : 8'h13], 16'hDEAD);
      end

      // PC wrap: JMP 0xFF, NOP at 0xFF, next fetch from 0x00.
      clear_img();
      img[0] = 16'h60FF;
      run_prog(40);
      chk(act_q.size() >= 3 && act_q[1].addr == 8'hFF && act_q[2].addr == 8'h00, "pc_wrap",
          act_q.size() >= 3 ? {act_q[1].addr, act_q[2].addr} : 16'hXXXX, 16'hFF00);

      // Self-modifying store turns a JMP into HALT before it is fetched.
      clear_img();
      img[0] = 16'h1010; img[1] = 16'h2002; img[2] = 16'h6000; img[8'h10] = 16'hF000;
      run_prog(60);
      chk(halted, "selfmod_halt", {31'd0, halted}, 1);

      // Random programs against the instruction-level model.
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 256; i++) begin
            r  = 16'($urandom);
            op = r[15:12];
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
            img[i] = {op, r[11:0]};
         end
         run_prog(500);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
